// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and one peripheral
// requester. The CPU normally wins. A starvation counter forces one peripheral slot,
// which stalls the CPU for exactly one cycle.
module dmem_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              per_req,
   input  logic              per_wren,
   input  logic [ADDR_W-1:0] per_addr,
   input  logic [DATA_W-1:0] per_wdata,
   output logic              per_gnt,
   output logic              per_rvalid,
   output logic [DATA_W-1:0] per_rdata,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [0:0] {
      CPU_PRI   = 1'b0,
      FORCE_PER = 1'b1
   } state_t;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   state_t      state_r;
   state_t      state_nxt;
   logic [7:0]  starve_r;
   logic [7:0]  starve_nxt;
   logic        per_rvalid_r;
   logic        cpu_gnt;

   // State, starvation counter and read-valid tag; pending rvalid is dropped by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= CPU_PRI;
         starve_r     <= 8'd0;
         per_rvalid_r <= 1'b0;
      end else begin
         state_r      <= state_nxt;
         starve_r     <= starve_nxt;
         per_rvalid_r <= per_gnt & ~per_wren;
      end
   end

   // Grant/stall decision and next state. Grants are held off while reset is asserted
   // so every output shows its reset value immediately.
   always_comb begin
      state_nxt  = state_r;
      starve_nxt = starve_r;
      per_gnt    = 1'b0;
      cpu_gnt    = 1'b0;
      cpu_stall  = 1'b0;
      if (reset) begin
         case (state_r)
            CPU_PRI: begin
               if (cpu_req) begin
                  cpu_gnt = 1'b1;
               end else if (per_req) begin
                  per_gnt = 1'b1;
               end else begin
                  cpu_gnt = 1'b0;
               end
               if (per_req && !per_gnt) begin
                  // Saturating count; a full count forces the next slot to the peripheral.
                  if (starve_r >= STARVE_LIM) begin
                     starve_nxt = STARVE_LIM;
                     state_nxt  = FORCE_PER;
                  end else begin
                     starve_nxt = starve_r + 8'd1;
                  end
               end else begin
                  starve_nxt = 8'd0;
               end
            end
            FORCE_PER: begin
               // If the peripheral gave up meanwhile, the CPU proceeds unstalled.
               per_gnt    = per_req;
               cpu_stall  = cpu_req & per_req;
               cpu_gnt    = cpu_req & ~per_req;
               starve_nxt = 8'd0;
               state_nxt  = CPU_PRI;
            end
            default: begin
               starve_nxt = 8'd0;
               state_nxt  = CPU_PRI;
            end
         endcase
      end else begin
         state_nxt  = CPU_PRI;
         starve_nxt = 8'd0;
      end
   end

   // RAM port mux: granted side drives the RAM; idle cycles present the CPU address.
   always_comb begin
      mem_wren  = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (per_gnt) begin
         mem_wren  = per_wren;
         mem_addr  = per_addr;
         mem_wdata = per_wdata;
      end else if (cpu_gnt) begin
         mem_wren  = cpu_wren;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else begin
         mem_wren  = 1'b0;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign cpu_rdata  = mem_rdata;
   assign per_rvalid = per_rvalid_r;
   assign per_rdata  = per_rvalid_r ? mem_rdata : {DATA_W{1'b0}};

endmodule
